// File: rtl/saturate_sub_multi.sv
// Time-multiplexed two-stage saturating subtractor with per-channel saturation-event counters.
// Define SATSUB_COUNTERS_EN to build the counters, rdData and clrStrobe; otherwise rdData reads 0.
module saturate_sub_multi #(
    parameter int AWIDTH    = 16,
    parameter int BWIDTH    = 16,
    parameter int DIFFWIDTH = 16,
    parameter int NCHAN     = 8,
    parameter int CNTWIDTH  = 16,
    localparam int CHANW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                 sysClk,
    input  logic                 sysReset_n,
    input  logic                 inValid,
    input  logic [CHANW-1:0]     inChan,
    input  logic                 inUnsigned,
    input  logic [AWIDTH-1:0]    A,
    input  logic [BWIDTH-1:0]    B,
    output logic                 outValid,
    output logic [CHANW-1:0]     outChan,
    output logic [DIFFWIDTH-1:0] DIFF,
    output logic                 satHi,
    output logic                 satLo,
    input  logic [CHANW-1:0]     rdChan,
    output logic [CNTWIDTH-1:0]  rdData,
    input  logic                 clrStrobe
);

    localparam int FULLWIDTH = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1;

    logic signed [FULLWIDTH-1:0] a_ext;
    logic signed [FULLWIDTH-1:0] b_ext;
    logic signed [FULLWIDTH-1:0] s1_diff;
    logic                        s1_valid;
    logic [CHANW-1:0]            s1_chan;
    logic                        s1_uns;
    logic [DIFFWIDTH-1:0]        diff_c;
    logic                        hi_c;
    logic                        lo_c;

    // One extra bit over the wider operand keeps the difference exact in both modes.
    always_comb begin
        a_ext = {{(FULLWIDTH-AWIDTH){A[AWIDTH-1] & ~inUnsigned}}, A};
        b_ext = {{(FULLWIDTH-BWIDTH){B[BWIDTH-1] & ~inUnsigned}}, B};
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            s1_valid <= 1'b0;
            s1_chan  <= '0;
            s1_uns   <= 1'b0;
            s1_diff  <= '0;
        end else begin
            s1_valid <= inValid;
            s1_chan  <= inChan;
            s1_uns   <= inUnsigned;
            s1_diff  <= a_ext - b_ext;
        end
    end

    generate
        if (DIFFWIDTH >= FULLWIDTH) begin : g_nosat
            always_comb begin
                hi_c = 1'b0;
                lo_c = 1'b0;
                if (s1_uns) begin
                    diff_c = DIFFWIDTH'($unsigned(s1_diff));
                end else begin
                    diff_c = DIFFWIDTH'(s1_diff);
                end
            end
        end else begin : g_sat
            localparam logic signed [FULLWIDTH-1:0] SMAX =
                {{(FULLWIDTH-DIFFWIDTH+1){1'b0}}, {(DIFFWIDTH-1){1'b1}}};
            localparam logic signed [FULLWIDTH-1:0] SMIN = ~SMAX;
            localparam logic signed [FULLWIDTH-1:0] UMAX =
                {{(FULLWIDTH-DIFFWIDTH){1'b0}}, {DIFFWIDTH{1'b1}}};

            always_comb begin
                hi_c   = 1'b0;
                lo_c   = 1'b0;
                diff_c = s1_diff[DIFFWIDTH-1:0];
                if (s1_uns) begin
                    if (s1_diff[FULLWIDTH-1]) begin
                        lo_c   = 1'b1;
                        diff_c = '0;
                    end else if (s1_diff > UMAX) begin
                        hi_c   = 1'b1;
                        diff_c = '1;
                    end
                end else begin
                    if (s1_diff > SMAX) begin
                        hi_c   = 1'b1;
                        diff_c = SMAX[DIFFWIDTH-1:0];
                    end else if (s1_diff < SMIN) begin
                        lo_c   = 1'b1;
                        diff_c = SMIN[DIFFWIDTH-1:0];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            outValid <= 1'b0;
            outChan  <= '0;
            DIFF     <= '0;
            satHi    <= 1'b0;
            satLo    <= 1'b0;
        end else begin
            outValid <= s1_valid;
            outChan  <= s1_chan;
            DIFF     <= diff_c;
            satHi    <= s1_valid & hi_c;
            satLo    <= s1_valid & lo_c;
        end
    end

`ifdef SATSUB_COUNTERS_EN
    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    logic [CNTWIDTH-1:0] cnt_q [NCHAN];
    logic [CNTWIDTH-1:0] cnt_d [NCHAN];
    logic [CNTWIDTH-1:0] rd_d;

    // rdData samples the next counter value so an event shows one cycle after outValid.
    // Channels >= NCHAN match no entry, so their events are dropped.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clrStrobe && (rdChan == CHANW'(i))) begin
                cnt_d[i] = '0;
            end else if (outValid && (satHi || satLo) && (outChan == CHANW'(i))
                         && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNTWIDTH'(1);
            end
            if (rdChan == CHANW'(i)) begin
                rd_d = cnt_d[i];
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= '0;
            end
            rdData <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rdData <= rd_d;
        end
    end
`else
    logic unused_rd_ports;

    assign unused_rd_ports = ^{clrStrobe, rdChan};
    assign rdData          = '0;
`endif

endmodule

// File: tb/tb_saturate_sub_multi.sv
// Directed bench for saturate_sub_multi (8-bit datapath, 4-bit counters) plus a 12-bit
// non-saturating instance; counter checks follow whether SATSUB_COUNTERS_EN is defined.
module tb_saturate_sub_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_chan;
    logic        in_uns;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  rd_chan;
    logic        clr;

    logic        out_valid;
    logic [2:0]  out_chan;
    logic [7:0]  diff;
    logic        sat_hi;
    logic        sat_lo;
    logic [3:0]  rd_data;

    logic        w_out_valid;
    logic [2:0]  w_out_chan;
    logic [11:0] w_diff;
    logic        w_sat_hi;
    logic        w_sat_lo;
    logic [3:0]  w_rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    saturate_sub_multi #(
        .AWIDTH(8), .BWIDTH(8), .DIFFWIDTH(8), .NCHAN(8), .CNTWIDTH(4)
    ) dut (
        .sysClk(clk), .sysReset_n(rst_n), .inValid(in_valid), .inChan(in_chan),
        .inUnsigned(in_uns), .A(a), .B(b), .outValid(out_valid), .outChan(out_chan),
        .DIFF(diff), .satHi(sat_hi), .satLo(sat_lo), .rdChan(rd_chan),
        .rdData(rd_data), .clrStrobe(clr)
    );

    saturate_sub_multi #(
        .AWIDTH(8), .BWIDTH(8), .DIFFWIDTH(12), .NCHAN(8), .CNTWIDTH(4)
    ) dut_wide (
        .sysClk(clk), .sysReset_n(rst_n), .inValid(in_valid), .inChan(in_chan),
        .inUnsigned(in_uns), .A(a), .B(b), .outValid(w_out_valid), .outChan(w_out_chan),
        .DIFF(w_diff), .satHi(w_sat_hi), .satLo(w_sat_lo), .rdChan(rd_chan),
        .rdData(w_rd_data), .clrStrobe(clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid, out_chan, diff, sat_hi, sat_lo} !== 14'd0) begin
            bad++;
            $display("FAIL reset_out got=%b exp=0", {out_valid, out_chan, diff, sat_hi, sat_lo});
        end
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL reset_rd got=%0d exp=0", rd_data);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b%b exp=00", out_valid, w_out_valid);
        end
    endtask

    task automatic test_signed();
        int va [6] = '{100, -128, 20, 127, -1, 126};
        int vb [6] = '{-100, 1, 30, -128, 127, -1};
        int ed [6] = '{127, -128, -10, 127, -128, 127};
        bit eh [6] = '{1, 0, 0, 1, 0, 0};
        bit el [6] = '{0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_uns = 1'b0; in_chan = 3'(i);
            a = 8'(va[i]); b = 8'(vb[i]);
            tick();
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL sig_early[%0d] got=%b exp=0", i, out_valid);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_chan !== 3'(i) || diff !== 8'(ed[i])
                || sat_hi !== eh[i] || sat_lo !== el[i]) begin
                bad++;
                $display("FAIL sig_out[%0d] got v=%b ch=%0d d=%0d hi=%b lo=%b exp v=1 ch=%0d d=%0d hi=%b lo=%b",
                         i, out_valid, out_chan, $signed(diff), sat_hi, sat_lo, i, ed[i], eh[i], el[i]);
            end
            total++;
            if (w_out_valid !== 1'b1 || w_diff !== 12'(va[i] - vb[i]) || w_sat_hi !== 1'b0
                || w_sat_lo !== 1'b0) begin
                bad++;
                $display("FAIL sig_wide[%0d] got v=%b d=%0d hi=%b lo=%b exp v=1 d=%0d hi=0 lo=0",
                         i, w_out_valid, $signed(w_diff), w_sat_hi, w_sat_lo, va[i] - vb[i]);
            end
            tick();
            total++;
            if (out_valid !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
                bad++;
                $display("FAIL sig_late[%0d] got v=%b hi=%b lo=%b exp 0 0 0", i, out_valid, sat_hi, sat_lo);
            end
        end
    endtask

    task automatic test_unsigned();
        int va [5] = '{5, 255, 0, 255, 200};
        int vb [5] = '{10, 0, 1, 255, 100};
        int ed [5] = '{0, 255, 0, 0, 100};
        bit el [5] = '{1, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_uns = 1'b1; in_chan = 3'(7 - i);
            a = 8'(va[i]); b = 8'(vb[i]);
            tick();
            in_valid = 1'b0;
            tick();
            total++;
            if (out_valid !== 1'b1 || out_chan !== 3'(7 - i) || diff !== 8'(ed[i])
                || sat_hi !== 1'b0 || sat_lo !== el[i]) begin
                bad++;
                $display("FAIL uns_out[%0d] got v=%b ch=%0d d=%0d hi=%b lo=%b exp v=1 ch=%0d d=%0d hi=0 lo=%b",
                         i, out_valid, out_chan, diff, sat_hi, sat_lo, 7 - i, ed[i], el[i]);
            end
            if (va[i] >= vb[i]) begin
                total++;
                if (w_diff !== 12'(va[i] - vb[i]) || w_sat_hi !== 1'b0 || w_sat_lo !== 1'b0) begin
                    bad++;
                    $display("FAIL uns_wide[%0d] got d=%0d hi=%b lo=%b exp d=%0d hi=0 lo=0",
                             i, w_diff, w_sat_hi, w_sat_lo, va[i] - vb[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (cyc < 16) begin
                in_valid = 1'b1; in_uns = 1'b0; in_chan = 3'(cyc % 8);
                a = 8'(cyc); b = 8'd0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (cyc >= 1 && cyc <= 16) begin
                total++;
                if (out_valid !== 1'b1 || out_chan !== 3'((cyc - 1) % 8) || diff !== 8'(cyc - 1)) begin
                    bad++;
                    $display("FAIL b2b[%0d] got v=%b ch=%0d d=%0d exp v=1 ch=%0d d=%0d",
                             cyc - 1, out_valid, out_chan, diff, (cyc - 1) % 8, cyc - 1);
                end
            end
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_tail got v=%b exp 0", out_valid);
        end
    endtask

`ifdef SATSUB_COUNTERS_EN
    task automatic test_counters();
        rd_chan = 3'd3; clr = 1'b0;
        in_valid = 1'b1; in_uns = 1'b0; in_chan = 3'd3; a = 8'd100; b = 8'(-100);
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL cnt_early got=%0d exp=0", rd_data);
        end
        tick();
        total++;
        if (rd_data !== 4'd1) begin
            bad++;
            $display("FAIL cnt_one got=%0d exp=1", rd_data);
        end
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        total++;
        if (rd_data !== 4'd15) begin
            bad++;
            $display("FAIL cnt_hold got=%0d exp=15", rd_data);
        end
        rd_chan = 3'd2;
        in_valid = 1'b1; in_chan = 3'd2; a = 8'd20; b = 8'd30;
        tick();
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL cnt_other got=%0d exp=0", rd_data);
        end
    endtask

    task automatic test_clear();
        rd_chan = 3'd3;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL clr_alone got=%0d exp=0", rd_data);
        end
        in_valid = 1'b1; in_uns = 1'b0; in_chan = 3'd3; a = 8'd100; b = 8'(-100);
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1 || sat_hi !== 1'b1 || out_chan !== 3'd3) begin
            bad++;
            $display("FAIL clr_align got v=%b hi=%b ch=%0d exp v=1 hi=1 ch=3", out_valid, sat_hi, out_chan);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL clr_prio got=%0d exp=0", rd_data);
        end
        tick();
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL clr_prio2 got=%0d exp=0", rd_data);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (rd_data !== 4'd1) begin
            bad++;
            $display("FAIL clr_resume got=%0d exp=1", rd_data);
        end
    endtask
`else
    task automatic test_counters_off();
        rd_chan = 3'd3;
        in_uns = 1'b0; in_chan = 3'd3; a = 8'd100; b = 8'(-100);
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 20);
            clr = i[0];
            tick();
            total++;
            if (rd_data !== 4'd0) begin
                bad++;
                $display("FAIL cnt_off[%0d] got=%0d exp=0", i, rd_data);
            end
        end
        clr = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        in_valid = 1'b1; in_uns = 1'b0; in_chan = 3'd5; a = 8'd100; b = 8'(-100);
        tick();
        in_chan = 3'd6; a = 8'(-128); b = 8'd1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || sat_hi !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got v=%b hi=%b exp 1 1", out_valid, sat_hi);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_chan, diff, sat_hi, sat_lo, rd_data} !== 18'd0) begin
            bad++;
            $display("FAIL rmid_zero got=%b exp=0", {out_valid, out_chan, diff, sat_hi, sat_lo, rd_data});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || sat_lo !== 1'b0 || sat_hi !== 1'b0) begin
                bad++;
                $display("FAIL rmid_ghost[%0d] got v=%b hi=%b lo=%b exp 0 0 0", i, out_valid, sat_hi, sat_lo);
            end
        end
        rd_chan = 3'd3;
        tick();
        total++;
        if (rd_data !== 4'd0) begin
            bad++;
            $display("FAIL rmid_cnt got=%0d exp=0", rd_data);
        end
        in_valid = 1'b1; in_chan = 3'd1; a = 8'd20; b = 8'd30;
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_chan !== 3'd1 || diff !== 8'hF6 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            bad++;
            $display("FAIL rmid_after got v=%b ch=%0d d=%0d hi=%b lo=%b exp v=1 ch=1 d=-10 hi=0 lo=0",
                     out_valid, out_chan, $signed(diff), sat_hi, sat_lo);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_chan = '0; in_uns = 1'b0;
        a = '0; b = '0; rd_chan = '0; clr = 1'b0;
        repeat (3) tick();
        test_reset();
        test_signed();
        test_unsigned();
        test_back_to_back();
`ifdef SATSUB_COUNTERS_EN
        test_counters();
        test_clear();
`else
        test_counters_off();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
